// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush controller for the five-stage pipeline.
// Drives the stall/clear inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB
// registers from memory handshakes, mul/div occupancy, load-use hazards and
// EX-stage branch redirects. It also discards a wrong-path fetch response
// when a redirect lands while a fetch is still in flight.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   ireq_valid, iresp_ok        fetch request outstanding / response valid
//   dreq_valid, dresp_ok        MEM data request outstanding / response valid
//   muldiv_start, muldiv_done   mul/div issue from EX / result ready
//   ex_memread, ex_rd           EX-stage load flag and destination register
//   id_rs1/2, id_rs1/2_used     ID-stage source registers and read enables
//   branch_redirect             EX resolved a taken/mispredicted branch
//   stall_F/D/E/M               hold PC, IF/ID, ID/EX, EX/MEM (combinational)
//   clr_D/E/M/W                 clear IF/ID, ID/EX, EX/MEM, MEM/WB (combinational)
//   redirect_fire               fetch loads the branch target this cycle
//   stall_cycles                (PIPE_STALL_CNT_EN only) count of stall_F cycles
//
// Build option: define PIPE_STALL_CNT_EN to add the 64-bit stall_cycles counter.

module pipe_hazard_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       ireq_valid,
  input  logic       iresp_ok,
  input  logic       dreq_valid,
  input  logic       dresp_ok,
  input  logic       muldiv_start,
  input  logic       muldiv_done,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic       branch_redirect,
  output logic       stall_F,
  output logic       stall_D,
  output logic       stall_E,
  output logic       stall_M,
  output logic       clr_D,
  output logic       clr_E,
  output logic       clr_M,
  output logic       clr_W,
`ifdef PIPE_STALL_CNT_EN
  output logic       redirect_fire,
  output logic [63:0] stall_cycles
`else
  output logic       redirect_fire
`endif
);

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] XZR = REG_W'(31);

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } mdivState_t;

  mdivState_t mdivState, mdivStateNext;
  logic       dropPend, dropPendNext;

  logic memBusy, fetchBusy, mdBusy, loadUse;

  // Hazard terms
  assign memBusy   = dreq_valid & ~dresp_ok;
  assign fetchBusy = ireq_valid & ~iresp_ok;
  assign mdBusy    = ((mdivState == MD_BUSY) & ~muldiv_done) |
                     (muldiv_start & ~muldiv_done);
  assign loadUse   = ex_memread & (ex_rd != XZR) &
                     ((id_rs1_used & (id_rs1 == ex_rd)) |
                      (id_rs2_used & (id_rs2 == ex_rd)));

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mdivState <= MD_IDLE;
      dropPend  <= 1'b0;
    end else begin
      mdivState <= mdivStateNext;
      dropPend  <= dropPendNext;
    end
  end

  // Next-state and prioritised stall/clear outputs
  always_comb begin
    stall_F       = 1'b0;
    stall_D       = 1'b0;
    stall_E       = 1'b0;
    stall_M       = 1'b0;
    clr_D         = 1'b0;
    clr_E         = 1'b0;
    clr_M         = 1'b0;
    clr_W         = 1'b0;
    redirect_fire = 1'b0;
    mdivStateNext = mdivState;
    dropPendNext  = dropPend;

    if (rst) begin
      clr_D = 1'b1;
      clr_E = 1'b1;
      clr_M = 1'b1;
      clr_W = 1'b1;
    end else if (memBusy) begin
      // Whole pipe frozen; a pending redirect stays in the held EX stage
      stall_F = 1'b1;
      stall_D = 1'b1;
      stall_E = 1'b1;
      stall_M = 1'b1;
      clr_W   = 1'b1;
    end else if (mdBusy) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      stall_E = 1'b1;
      clr_M   = 1'b1;
    end else begin
      // Redirect beats load-use: the consumer in ID is on the wrong path
      if (branch_redirect) begin
        redirect_fire = 1'b1;
        clr_D         = 1'b1;
        clr_E         = 1'b1;
      end else if (loadUse) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        clr_E   = 1'b1;
      end

      // Fetch not delivered: hold PC and bubble IF/ID unless ID is held
      if (fetchBusy) begin
        stall_F = 1'b1;
        if (!stall_D) clr_D = 1'b1;
      end

      // Response for a fetch issued before the redirect is wrong-path
      if (dropPend && iresp_ok) clr_D = 1'b1;
    end

    if (!rst) begin
      unique case (mdivState)
        MD_IDLE: if (muldiv_start && !muldiv_done && !memBusy) mdivStateNext = MD_BUSY;
        MD_BUSY: if (muldiv_done) mdivStateNext = MD_IDLE;
        default: mdivStateNext = MD_IDLE;
      endcase

      if (redirect_fire && fetchBusy) dropPendNext = 1'b1;
      else if (iresp_ok)              dropPendNext = 1'b0;
    end
  end

`ifdef PIPE_STALL_CNT_EN
  localparam int unsigned CNT_W = 64;
  logic [CNT_W-1:0] stallCnt;

  // Free-running fetch-stall counter, wraps naturally
  always_ff @(posedge clk) begin
    if (rst)          stallCnt <= '0;
    else if (stall_F) stallCnt <= stallCnt + CNT_W'(1);
  end

  assign stall_cycles = stallCnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for pipe_hazard_ctrl. Each stimulus
// cycle pushes its expected output vector; the negedge monitor pops and
// compares against the live outputs.
// Output vector order: {stall_F,stall_D,stall_E,stall_M,clr_D,clr_E,clr_M,clr_W,redirect_fire}

module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       ireq_valid, iresp_ok, dreq_valid, dresp_ok;
  logic       muldiv_start, muldiv_done, ex_memread;
  logic [4:0] ex_rd, id_rs1, id_rs2;
  logic       id_rs1_used, id_rs2_used, branch_redirect;
  logic       stall_F, stall_D, stall_E, stall_M;
  logic       clr_D, clr_E, clr_M, clr_W, redirect_fire;
`ifdef PIPE_STALL_CNT_EN
  logic [63:0] stall_cycles;
  logic [63:0] expCnt;
`endif

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .ireq_valid(ireq_valid), .iresp_ok(iresp_ok),
    .dreq_valid(dreq_valid), .dresp_ok(dresp_ok),
    .muldiv_start(muldiv_start), .muldiv_done(muldiv_done),
    .ex_memread(ex_memread), .ex_rd(ex_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .branch_redirect(branch_redirect),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
    .clr_D(clr_D), .clr_E(clr_E), .clr_M(clr_M), .clr_W(clr_W),
`ifdef PIPE_STALL_CNT_EN
    .redirect_fire(redirect_fire),
    .stall_cycles(stall_cycles)
`else
    .redirect_fire(redirect_fire)
`endif
  );

  // Expected output patterns
  localparam logic [8:0] NONE     = 9'b0000_0000_0;
  localparam logic [8:0] RSTV     = 9'b0000_1111_0;
  localparam logic [8:0] MEMW     = 9'b1111_0001_0;
  localparam logic [8:0] MDW      = 9'b1110_0010_0;
  localparam logic [8:0] REDIR    = 9'b0000_1100_1;
  localparam logic [8:0] LU       = 9'b1100_0100_0;
  localparam logic [8:0] FB       = 9'b1000_1000_0;
  localparam logic [8:0] REDIR_FB = 9'b1000_1100_1;
  localparam logic [8:0] DROP     = 9'b0000_1000_0;

  int total = 0;
  int bad   = 0;

  logic [8:0] expQ[$];
  string      tagQ[$];

  logic [8:0] outs;
  assign outs = {stall_F, stall_D, stall_E, stall_M, clr_D, clr_E, clr_M, clr_W, redirect_fire};

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Monitor: compare outputs mid-cycle against the scoreboard head
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      logic [8:0] e;
      string      t;
      e = expQ.pop_front();
      t = tagQ.pop_front();
      checkVal(t, 64'(outs), 64'(e));
    end
  end

  task automatic idle();
    rst = 1'b0; ireq_valid = 1'b0; iresp_ok = 1'b0; dreq_valid = 1'b0; dresp_ok = 1'b0;
    muldiv_start = 1'b0; muldiv_done = 1'b0; ex_memread = 1'b0;
    ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; branch_redirect = 1'b0;
  endtask

  // One cycle of already-applied inputs with its expected outputs
  task automatic cyc(input string tag, input logic [8:0] exp);
    expQ.push_back(exp);
    tagQ.push_back(tag);
`ifdef PIPE_STALL_CNT_EN
    if (rst) expCnt = 64'd0;
    else     expCnt = expCnt + 64'(exp[8]);
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef PIPE_STALL_CNT_EN
    expCnt = 64'd0;
`endif
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    cyc("reset0", RSTV);
    cyc("reset1", RSTV);
`ifdef PIPE_STALL_CNT_EN
    checkVal("cnt_after_reset", stall_cycles, 64'd0);
`endif
    idle();
    cyc("idle", NONE);

    // Load-use on rs1, one bubble only
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
    cyc("lu_rs1", LU);
    idle();
    cyc("lu_after", NONE);

    // Load-use on rs2, then same regs with rs2 unused
    ex_memread = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_rs2_used = 1'b1;
    cyc("lu_rs2", LU);
    id_rs2_used = 1'b0;
    cyc("lu_rs2_unused", NONE);
    idle();

    // XZR destination never hazards
    ex_memread = 1'b1; ex_rd = 5'd31; id_rs1 = 5'd31; id_rs1_used = 1'b1;
    cyc("lu_xzr", NONE);
    idle();

    // Data wait with a redirect held throughout
    dreq_valid = 1'b1; branch_redirect = 1'b1;
    for (int i = 0; i < 3; i++) cyc($sformatf("dwait%0d", i), MEMW);
    dresp_ok = 1'b1;
    cyc("dwait_done_redir", REDIR);
    idle();

    // Mul/div start t0, done t4
    muldiv_start = 1'b1;
    cyc("md_t0", MDW);
    muldiv_start = 1'b0;
    for (int i = 1; i < 4; i++) cyc($sformatf("md_t%0d", i), MDW);
    muldiv_done = 1'b1;
    cyc("md_t4", NONE);
    idle();
    cyc("md_t5", NONE);

    // Start and done together: no occupancy
    muldiv_start = 1'b1; muldiv_done = 1'b1;
    cyc("md_same", NONE);
    idle();
    cyc("md_same_after", NONE);

    // Mul/div start blocked by a data wait does not enter busy
    dreq_valid = 1'b1; muldiv_start = 1'b1;
    cyc("md_blocked", MEMW);
    idle();
    cyc("md_blocked_after", NONE);

    // Redirect during in-flight fetch, wrong-path response two cycles later
    ireq_valid = 1'b1; branch_redirect = 1'b1;
    cyc("rf_fire", REDIR_FB);
    branch_redirect = 1'b0;
    cyc("rf_wait", FB);
    iresp_ok = 1'b1;
    cyc("rf_drop", DROP);
    ireq_valid = 1'b0;
    cyc("rf_cleared", NONE);
    idle();

    // Fetch busy alone, and with load-use (ID held, so no IF/ID clear)
    ireq_valid = 1'b1;
    cyc("fetch_busy", FB);
    ex_memread = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_rs1_used = 1'b1;
    cyc("fetch_busy_lu", LU);
    idle();

    // Redirect overrides load-use
    ex_memread = 1'b1; ex_rd = 5'd3; id_rs2 = 5'd3; id_rs2_used = 1'b1; branch_redirect = 1'b1;
    cyc("redir_vs_lu", REDIR);
    idle();

    // Reset while busy and with a pending drop
    ireq_valid = 1'b1; branch_redirect = 1'b1;
    cyc("rst_setup_drop", REDIR_FB);
    idle();
    muldiv_start = 1'b1;
    cyc("rst_setup_md", MDW);
    idle();
    rst = 1'b1;
    cyc("rst_mid", RSTV);
`ifdef PIPE_STALL_CNT_EN
    checkVal("cnt_reset_mid", stall_cycles, 64'd0);
`endif
    idle();
    iresp_ok = 1'b1;
    cyc("rst_post", NONE);
    idle();
    cyc("rst_post2", NONE);

    // A few more stall cycles for the counter
    muldiv_start = 1'b1;
    cyc("cnt_md0", MDW);
    muldiv_start = 1'b0;
    cyc("cnt_md1", MDW);
    muldiv_done = 1'b1;
    cyc("cnt_md2", NONE);
    idle();
    cyc("final_idle", NONE);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 4 && expQ.size() > 0; i++) @(negedge clk);
    #1;
    checkVal("drain", 64'(expQ.size()), 64'd0);
`ifdef PIPE_STALL_CNT_EN
    checkVal("cnt_final", stall_cycles, expCnt);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
